alu_exec_checker: RTL and testbench

//  Sequential driver/checker on the operand side of the 16-bit ALU port (ain, bin, alu_op -> out, status).

---
 rtl/alu_exec_checker.sv | 141 ++++++++++++++
 tb/tb_alu_exec_checker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_checker.sv
// rtl/alu_exec_checker.sv - ALU operand driver with settle window, golden-model compare and counters
//
// Accepts one ALU operation per request, presents the registered operands to the ALU,
// waits SETTLE_CYCLES rising edges, captures the ALU result/status, compares them with
// an internal reference computed from the same registered operands, and returns the
// captured values with a mismatch flag.
//
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   req_valid/req_ready                  request handshake (ready only in IDLE)
//   req_ain, req_bin, req_op             operands and op (00 add, 01 sub, 10 and, 11 not B)
//   alu_ain, alu_bin, alu_op             registered operands driven to the ALU
//   alu_out, alu_status                  ALU result and zero flag
//   rsp_valid/rsp_ready                  response handshake (valid only in RESP)
//   rsp_data, rsp_status, rsp_mismatch   captured result, status and compare flag
//   txn_count, err_count                 saturating completed / mismatching response counts
module alu_exec_checker #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_ain,
    input  logic [WIDTH-1:0] req_bin,
    input  logic [1:0]       req_op,
    output logic [WIDTH-1:0] alu_ain,
    output logic [WIDTH-1:0] alu_bin,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_status,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_status,
    output logic             rsp_mismatch,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_next;
    logic [SET_W-1:0] settle_cnt;
    logic             accept;
    logic             settle_done;
    logic             rsp_done;
    logic [WIDTH-1:0] expected;
    logic             expected_status;
    logic             mismatch_now;

    assign req_ready   = (state == IDLE);
    assign rsp_valid   = (state == RESP);
    assign accept      = (state == IDLE) && req_valid;
    // The counter holds the number of edges still to wait; the edge that sees 1 is the capture edge.
    assign settle_done = (state == EXEC) && (settle_cnt == SET_W'(1));
    assign rsp_done    = (state == RESP) && rsp_ready;

    // Reference result is taken from the registered operands, i.e. exactly what the ALU sees.
    always_comb begin
        expected = '0;
        case (alu_op)
            2'b00:   expected = alu_ain + alu_bin;
            2'b01:   expected = alu_ain - alu_bin;
            2'b10:   expected = alu_ain & alu_bin;
            default: expected = ~alu_bin;
        endcase
    end

    assign expected_status = (expected == '0);
    assign mismatch_now    = (alu_out != expected) || (alu_status != expected_status);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)      state_next = EXEC;
            EXEC:    if (settle_done) state_next = RESP;
            RESP:    if (rsp_done)    state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_ain      <= '0;
            alu_bin      <= '0;
            alu_op       <= '0;
            settle_cnt   <= '0;
            rsp_data     <= '0;
            rsp_status   <= 1'b0;
            rsp_mismatch <= 1'b0;
            txn_count    <= '0;
            err_count    <= '0;
        end else begin
            if (accept) begin
                alu_ain    <= req_ain;
                alu_bin    <= req_bin;
                alu_op     <= req_op;
                settle_cnt <= SETTLE_LOAD;
            end else if (state == EXEC && !settle_done) begin
                settle_cnt <= settle_cnt - SET_W'(1);
            end

            if (settle_done) begin
                settle_cnt   <= '0;
                rsp_data     <= alu_out;
                rsp_status   <= alu_status;
                rsp_mismatch <= mismatch_now;
            end

            if (rsp_done) begin
                if (txn_count != CNT_MAX) begin
                    txn_count <= txn_count + CNT_W'(1);
                end
                if (rsp_mismatch && (err_count != CNT_MAX)) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_checker.sv
// tb/tb_alu_exec_checker.sv - scoreboard bench for alu_exec_checker (default and SETTLE=3/CNT_W=2 instances)
module tb_alu_exec_checker;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
        logic        m;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        req_valid [2];
    logic        req_ready [2];
    logic [15:0] req_ain [2];
    logic [15:0] req_bin [2];
    logic [1:0]  req_op [2];
    logic [15:0] alu_ain [2];
    logic [15:0] alu_bin [2];
    logic [1:0]  alu_op [2];
    logic [15:0] alu_out [2];
    logic        alu_status [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_data [2];
    logic        rsp_status [2];
    logic        rsp_mismatch [2];
    logic [15:0] txn_a, err_a;
    logic [1:0]  txn_b, err_b;

    logic        fault_zero = 1'b0;
    logic        fault_stat = 1'b0;
    logic        bad_b = 1'b0;

    int checks = 0;
    int failures = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    alu_exec_checker #(.WIDTH(16), .SETTLE_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_ain(req_ain[0]), .req_bin(req_bin[0]), .req_op(req_op[0]),
        .alu_ain(alu_ain[0]), .alu_bin(alu_bin[0]), .alu_op(alu_op[0]),
        .alu_out(alu_out[0]), .alu_status(alu_status[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .rsp_status(rsp_status[0]), .rsp_mismatch(rsp_mismatch[0]),
        .txn_count(txn_a), .err_count(err_a)
    );

    alu_exec_checker #(.WIDTH(16), .SETTLE_CYCLES(3), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_ain(req_ain[1]), .req_bin(req_bin[1]), .req_op(req_op[1]),
        .alu_ain(alu_ain[1]), .alu_bin(alu_bin[1]), .alu_op(alu_op[1]),
        .alu_out(alu_out[1]), .alu_status(alu_status[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .rsp_status(rsp_status[1]), .rsp_mismatch(rsp_mismatch[1]),
        .txn_count(txn_b), .err_count(err_b)
    );

    // Behavioural ALU driven by each DUT, with fault hooks.
    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return ~b;
        endcase
    endfunction

    assign alu_out[0]    = fault_zero ? 16'h0000 : alu_f(alu_ain[0], alu_bin[0], alu_op[0]);
    assign alu_status[0] = fault_stat | (alu_out[0] == 16'h0000);
    assign alu_out[1]    = bad_b ? 16'hDEAD : alu_f(alu_ain[1], alu_bin[1], alu_op[1]);
    assign alu_status[1] = (alu_out[1] == 16'h0000);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitors: pop an expected response whenever a response handshake is presented.
    always @(negedge clk) begin
        if (reset_n && rsp_valid[0] && rsp_ready[0]) begin
            if (qa.size() == 0) begin
                check("a_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_rsp_data", 32'(rsp_data[0]), 32'(e.d));
                check("a_rsp_status", 32'(rsp_status[0]), 32'(e.s));
                check("a_rsp_mismatch", 32'(rsp_mismatch[0]), 32'(e.m));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && rsp_valid[1] && rsp_ready[1]) begin
            if (qb.size() == 0) begin
                check("b_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_rsp_data", 32'(rsp_data[1]), 32'(e.d));
                check("b_rsp_status", 32'(rsp_status[1]), 32'(e.s));
                check("b_rsp_mismatch", 32'(rsp_mismatch[1]), 32'(e.m));
            end
        end
    end

    task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         input bit push, input exp_t e);
        int n;
        if (push) begin
            if (d == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
        req_ain[d]   = a;
        req_bin[d]   = b;
        req_op[d]    = op;
        req_valid[d] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!(rsp_valid[d] && rsp_ready[d]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(rsp_valid[d] && rsp_ready[d])) check("rsp_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int d, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                       input logic [15:0] ed, input logic es, input logic em);
        issue(d, a, b, op, 1'b1, '{d: ed, s: es, m: em});
        wait_done(d);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_ain[i]   = 16'h0;
            req_bin[i]   = 16'h0;
            req_op[i]    = 2'b00;
            rsp_ready[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready[0]), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("reset_alu_ain", 32'(alu_ain[0]), 32'd0);
        check("reset_txn", 32'(txn_a), 32'd0);
        reset_n = 1'b1;

        // Basic ops, A=0x001F B=0x000B
        txn(0, 16'h001F, 16'h000B, 2'b00, 16'h002A, 1'b0, 1'b0);
        txn(0, 16'h001F, 16'h000B, 2'b01, 16'h0014, 1'b0, 1'b0);
        txn(0, 16'h001F, 16'h000B, 2'b10, 16'h000B, 1'b0, 1'b0);
        txn(0, 16'h001F, 16'h000B, 2'b11, 16'hFFF4, 1'b0, 1'b0);
        check("t1_txn", 32'(txn_a), 32'd4);
        check("t1_err", 32'(err_a), 32'd0);

        // Wrap to zero sets status
        txn(0, 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b0);
        txn(0, 16'h000B, 16'h000B, 2'b01, 16'h0000, 1'b1, 1'b0);
        check("t2_txn", 32'(txn_a), 32'd6);

        // Faulty ALU: forced zero result, then forced status
        fault_zero = 1'b1;
        txn(0, 16'h001F, 16'h000B, 2'b00, 16'h0000, 1'b1, 1'b1);
        fault_zero = 1'b0;
        check("t3_err_zero", 32'(err_a), 32'd1);
        fault_stat = 1'b1;
        txn(0, 16'h001F, 16'h000B, 2'b00, 16'h002A, 1'b1, 1'b1);
        fault_stat = 1'b0;
        check("t3_err_stat", 32'(err_a), 32'd2);
        check("t3_txn", 32'(txn_a), 32'd8);

        // Back-pressure in RESP
        rsp_ready[0] = 1'b0;
        issue(0, 16'h1234, 16'h0234, 2'b01, 1'b1, '{d: 16'h1000, s: 1'b0, m: 1'b0});
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            req_valid[0] = (i % 2 == 0);
            req_ain[0]   = 16'hAAAA;
            @(negedge clk);
            check("t4_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("t4_rsp_data", 32'(rsp_data[0]), 32'h1000);
            check("t4_req_ready", 32'(req_ready[0]), 32'd0);
        end
        req_valid[0] = 1'b0;
        check("t4_txn_hold", 32'(txn_a), 32'd8);
        @(posedge clk);
        #1 rsp_ready[0] = 1'b1;
        wait_done(0);
        check("t4_txn", 32'(txn_a), 32'd9);
        check("t4_err", 32'(err_a), 32'd2);
        check("t4_alu_ain_kept", 32'(alu_ain[0]), 32'h1234);
        check("t4_req_ready", 32'(req_ready[0]), 32'd1);

        // SETTLE_CYCLES=3: capture exactly on the third edge after accept
        bad_b = 1'b1;
        issue(1, 16'h0100, 16'h0023, 2'b00, 1'b1, '{d: 16'h0123, s: 1'b0, m: 1'b0});
        @(posedge clk);
        @(negedge clk);
        check("t5_valid_e1", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t5_valid_e2", 32'(rsp_valid[1]), 32'd0);
        bad_b = 1'b0;
        @(posedge clk);
        #1 bad_b = 1'b1;
        @(negedge clk);
        check("t5_valid_e3", 32'(rsp_valid[1]), 32'd1);
        @(posedge clk);
        #1 bad_b = 1'b0;

        // CNT_W=2 saturation
        txn(1, 16'hFF00, 16'h0F0F, 2'b10, 16'h0F00, 1'b0, 1'b0);
        txn(1, 16'h1234, 16'h0000, 2'b11, 16'hFFFF, 1'b0, 1'b0);
        txn(1, 16'h0005, 16'h0007, 2'b01, 16'hFFFE, 1'b0, 1'b0);
        txn(1, 16'h8000, 16'h8000, 2'b00, 16'h0000, 1'b1, 1'b0);
        check("t6_txn_sat", 32'(txn_b), 32'd3);
        check("t6_err_b", 32'(err_b), 32'd0);

        // Asynchronous reset mid-EXEC
        issue(0, 16'h5555, 16'h1111, 2'b00, 1'b0, '{d: 16'h0, s: 1'b0, m: 1'b0});
        reset_n = 1'b0;
        #1;
        check("t6_rst_req_ready", 32'(req_ready[0]), 32'd1);
        check("t6_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("t6_rst_alu_ain", 32'(alu_ain[0]), 32'd0);
        check("t6_rst_alu_bin", 32'(alu_bin[0]), 32'd0);
        check("t6_rst_rsp_data", 32'(rsp_data[0]), 32'd0);
        check("t6_rst_txn", 32'(txn_a), 32'd0);
        check("t6_rst_err", 32'(err_a), 32'd0);
        check("t6_rst_txn_b", 32'(txn_b), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_post_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("t6_post_txn", 32'(txn_a), 32'd0);

        check("queue_a_empty", 32'(qa.size()), 32'd0);
        check("queue_b_empty", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
